// File: rtl/t_toggle_counter.sv
// rtl/t_toggle_counter.sv - modulo-MOD up/down counter built from T-type toggle stages
//
// Purpose:
//   Synchronous modulo-MOD up/down counter. Each cycle it forms the toggle
//   vector T_VEC = Q ^ next_Q and applies it to the state register
//   (Q <= Q ^ T_VEC). T_VEC is exported so downstream toggle stages can be
//   driven from it. TC cascades into the EN of the next counter.
//
// Optional feature:
//   T_TOGGLE_COUNTER_SATURATE_EN - when defined, the counter holds at MOD-1
//   when counting up and at 0 when counting down, instead of wrapping. TC
//   still pulses for every attempted step at the limit. Ports are identical.
//
// Ports:
//   CLK     in   rising-edge clock
//   RST_N   in   asynchronous active-low reset (Q -> 0)
//   EN      in   count enable, one step per cycle
//   UP      in   direction, 1 = increment, 0 = decrement
//   LOAD    in   synchronous parallel load, priority over EN
//   D       in   load value, clamped to MOD-1
//   Q       out  current count (registered)
//   Q_Prime out  ~Q
//   T_VEC   out  toggle vector for the coming edge (combinational)
//   TC      out  terminal count (combinational)

module t_toggle_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_Prime,
  output logic [WIDTH-1:0] T_VEC,
  output logic             TC
);

  // Terminal value held one bit wider so MOD == 2**WIDTH still compares
  // correctly against D and Q.
  localparam logic [WIDTH:0] MAX = MOD[WIDTH:0] - 1'b1;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH-1:0] next_q;
  logic             at_top;
  logic             at_bottom;

  assign q_ext     = {1'b0, Q};
  assign d_ext     = {1'b0, D};
  // Up-count treats any illegal value (>= MOD) as terminal so it recovers to 0.
  assign at_top    = (q_ext >= MAX);
  assign at_bottom = (Q == '0);

  always_comb begin
    next_q = Q;
    if (LOAD) begin
      next_q = (d_ext <= MAX) ? D : MAX[WIDTH-1:0];
    end else if (EN) begin
      if (UP) begin
        if (at_top) begin
`ifdef T_TOGGLE_COUNTER_SATURATE_EN
          next_q = Q;
`else
          next_q = '0;
`endif
        end else begin
          next_q = Q + 1'b1;
        end
      end else begin
        if (at_bottom) begin
`ifdef T_TOGGLE_COUNTER_SATURATE_EN
          next_q = Q;
`else
          next_q = MAX[WIDTH-1:0];
`endif
        end else begin
          next_q = Q - 1'b1;
        end
      end
    end
  end

  assign T_VEC   = Q ^ next_q;
  assign Q_Prime = ~Q;
  // TC flags exactly MOD-1 (not illegal values) so cascades see one pulse per wrap.
  assign TC      = EN & ~LOAD & (UP ? (q_ext == MAX) : at_bottom);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= '0;
    end else begin
      Q <= Q ^ T_VEC;
    end
  end

endmodule

// File: tb/tb_t_toggle_counter.sv
// tb/tb_t_toggle_counter.sv - directed self-checking bench for t_toggle_counter
module tb_t_toggle_counter;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       UP;
  logic       LOAD;
  logic [3:0] D;
  logic [3:0] Q;
  logic [3:0] Q_Prime;
  logic [3:0] T_VEC;
  logic       TC;

  int checks = 0;
  int errors = 0;

  t_toggle_counter #(.WIDTH(4), .MOD(10)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
    .Q(Q), .Q_Prime(Q_Prime), .T_VEC(T_VEC), .TC(TC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    LOAD = 1'b1;
    D    = v;
    step();
    LOAD = 1'b0;
  endtask

  // Hand-computed up-wrap sequence from 0 over 12 edges.
  logic [3:0] up_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

  initial begin
    RST_N = 1'b0; EN = 1'b0; UP = 1'b1; LOAD = 1'b0; D = 4'd0;
    #2;
    check("rst_q",       32'(Q),       32'h0);
    check("rst_qp",      32'(Q_Prime), 32'hF);
    check("rst_tvec",    32'(T_VEC),   32'h0);
    check("rst_tc",      32'(TC),      32'h0);

    step();
    RST_N = 1'b1;
    step();
    check("release_hold", 32'(Q), 32'h0);

    // Count to 6, then reset between edges.
    EN = 1'b1; UP = 1'b1;
    repeat (6) step();
    check("count_to_6", 32'(Q), 32'h6);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_q",  32'(Q),       32'h0);
    check("async_rst_qp", 32'(Q_Prime), 32'hF);
    RST_N = 1'b1;
    EN = 1'b0;
    step();
    check("post_rst_hold", 32'(Q), 32'h0);
    EN = 1'b1;
    step();
    check("post_rst_first", 32'(Q), 32'h1);

`ifndef T_TOGGLE_COUNTER_SATURATE_EN
    // Up wrap from 0.
    EN = 1'b0;
    load(4'd0);
    EN = 1'b1; UP = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (Q == 4'd9) begin
        check("up_tc_at9",   32'(TC),    32'h1);
        check("up_tvec_at9", 32'(T_VEC), 32'h9);
      end else begin
        check("up_tc", 32'(TC), 32'h0);
      end
      step();
      check("up_seq", 32'(Q), 32'(up_seq[i]));
    end

    // Down wrap from 1.
    EN = 1'b0;
    load(4'd1);
    EN = 1'b1; UP = 1'b0;
    check("dn_tc_at1", 32'(TC), 32'h0);
    step();
    check("dn_q0",      32'(Q),     32'h0);
    check("dn_tc_at0",  32'(TC),    32'h1);
    check("dn_tvec_at0", 32'(T_VEC), 32'h9);
    step();
    check("dn_wrap9", 32'(Q), 32'h9);
`endif

    // Load priority and clamp.
    EN = 1'b1; UP = 1'b1; LOAD = 1'b1; D = 4'd7;
    #1;
    check("load_tc", 32'(TC), 32'h0);
    step();
    LOAD = 1'b0;
    check("load_7", 32'(Q), 32'h7);
    EN = 1'b0;
    load(4'd13);
    check("load_clamp13", 32'(Q), 32'h9);
    load(4'd15);
    check("load_clamp15", 32'(Q), 32'h9);
    load(4'd9);
    check("load_9", 32'(Q), 32'h9);

    // Hold and toggle vector.
    load(4'd3);
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_tvec", 32'(T_VEC), 32'h0);
      check("hold_tc",   32'(TC),    32'h0);
      step();
      check("hold_q",    32'(Q),     32'h3);
    end
    EN = 1'b1; UP = 1'b1;
    #1;
    check("tvec_3to4", 32'(T_VEC), 32'h7);
    step();
    check("q_4", 32'(Q), 32'h4);
    UP = 1'b0;
    #1;
    check("tvec_4to3", 32'(T_VEC), 32'h7);
    step();
    check("dir_change", 32'(Q), 32'h3);

`ifdef T_TOGGLE_COUNTER_SATURATE_EN
    EN = 1'b0;
    load(4'd9);
    EN = 1'b1; UP = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("sat_up_tc",   32'(TC),    32'h1);
      check("sat_up_tvec", 32'(T_VEC), 32'h0);
      step();
      check("sat_up_q",    32'(Q),     32'h9);
    end
    EN = 1'b0;
    load(4'd0);
    EN = 1'b1; UP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sat_dn_tc",   32'(TC),    32'h1);
      check("sat_dn_tvec", 32'(T_VEC), 32'h0);
      step();
      check("sat_dn_q",    32'(Q),     32'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
